edge_burst_writer: RTL

Drain side of the Sobel edge-magnitude FIFO. Watches the FIFO read-side fill count, pulls 8-bit edge pixels in fixed-size chunks, packs pixel pairs into 16-bit words in a local burst buffer, then hands each full burst to the SDRAM controller with a request/ack/next handshake. Sits between the edge FIFO read port and the SDRAM write channel, and maintains the frame write pointer.

---
 rtl/edge_wr_pkg.sv | 29 ++
 rtl/edge_burst_buf.sv | 31 +++
 rtl/edge_burst_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/edge_wr_pkg.sv
// edge_wr_pkg: shared definitions for the edge burst writer.
// Holds the writer FSM encoding, the pixel packing ratio and the default
// frame geometry from which the per-frame word count is derived.
package edge_wr_pkg;

  // Writer FSM states: wait for data, pull a burst, request, stream out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    REQ   = 2'd2,
    BURST = 2'd3
  } wr_state_t;

  // Two 8-bit edge pixels share one 16-bit SDRAM word.
  localparam int PIXELS_PER_WORD = 2;

  // Default frame geometry of the Sobel pipeline.
  localparam int DEFAULT_FRAME_WIDTH  = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;

  // Number of packed 16-bit words needed to hold one frame.
  function automatic int frame_words(input int width, input int height);
    return (width * height) / PIXELS_PER_WORD;
  endfunction

  localparam int DEFAULT_FRAME_WORDS =
    frame_words(DEFAULT_FRAME_WIDTH, DEFAULT_FRAME_HEIGHT);

endpackage

// File: rtl/edge_burst_buf.sv
// edge_burst_buf: local burst buffer of the edge writer.
// Simple dual-port RAM, one write port and one read port, both on clk.
// The read data is registered, so it appears one cycle after the address.
module edge_burst_buf #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a packed word whenever the fill side completes one.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/edge_burst_writer.sv
// edge_burst_writer: drains the Sobel edge-magnitude FIFO into SDRAM bursts.
// Pulls 2*BURST_LEN pixels per burst, packs pixel pairs into 16-bit words in
// a local buffer, then hands the burst to the SDRAM controller through a
// req/ack/next handshake while maintaining the frame write pointer.
// Build macro EDGE_THRESHOLD_EN: when defined each captured pixel is
// binarized against THRESHOLD (8'hFF / 8'h00) before packing; otherwise the
// raw magnitude is packed and THRESHOLD is unused.
module edge_burst_writer
  import edge_wr_pkg::*;
#(
  parameter int                    BURST_LEN   = 256,
  parameter int                    FRAME_WORDS = DEFAULT_FRAME_WORDS,
  parameter int                    ADDR_WIDTH  = 22,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = '0,
  parameter logic [7:0]            THRESHOLD   = 8'd40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            data_count_r,
  input  logic [7:0]            fifo_dout,
  output logic                  rd_fifo,
  input  logic                  frame_start,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_ack,
  input  logic                  wr_next,
  output logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = 10;
  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]      FILL_LAST = CNT_W'(PIXELS_PER_WORD * BURST_LEN);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP  = ADDR_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] PTR_END   = ADDR_WIDTH'(FRAME_WORDS);

  wr_state_t             state;
  wr_state_t             state_next;
  logic [CNT_W-1:0]      fill_cnt;
  logic                  fill_done;
  logic [7:0]            pixel;
  logic [7:0]            held_pixel;
  logic                  buf_we;
  logic [IDX_W-1:0]      buf_waddr;
  logic [15:0]           buf_wdata;
  logic [IDX_W-1:0]      buf_raddr;
  logic [15:0]           buf_rdata;
  logic [IDX_W-1:0]      burst_idx;
  logic [IDX_W-1:0]      idx_inc;
  logic                  burst_last;
  logic [ADDR_WIDTH-1:0] word_ptr;
  logic [ADDR_WIDTH-1:0] ptr_advanced;
  logic                  ptr_wrap;
  logic                  pending;

`ifdef EDGE_THRESHOLD_EN
  assign pixel = (fifo_dout >= THRESHOLD) ? 8'hFF : 8'h00;
`else
  logic unused_threshold;
  assign pixel            = fifo_dout;
  assign unused_threshold = ^THRESHOLD;
`endif

  // FILL ends on the cycle the last odd pixel lands, one cycle after the
  // final read strobe, which absorbs the FIFO read latency.
  assign fill_done = (state == FILL) && (fill_cnt == FILL_LAST);

  // Pixel c-1 arrives while fill_cnt == c; odd counts carry even pixels
  // (held), even counts carry odd pixels that complete word c/2-1.
  assign buf_we    = (state == FILL) && (fill_cnt != '0) && !fill_cnt[0];
  assign buf_waddr = IDX_W'((fill_cnt >> 1) - CNT_W'(1));
  assign buf_wdata = {pixel, held_pixel};

  assign burst_last   = (state == BURST) && wr_next && (burst_idx == IDX_LAST);
  assign idx_inc      = (burst_idx == IDX_LAST) ? '0 : burst_idx + IDX_W'(1);
  assign ptr_advanced = word_ptr + PTR_STEP;
  assign ptr_wrap     = (ptr_advanced == PTR_END);

  edge_burst_buf #(
    .DEPTH  (BURST_LEN),
    .WIDTH  (16),
    .ADDR_W (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: start on a full burst of pixels, finish on the last word.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (data_count_r >= FILL_LAST) state_next = FILL;
      FILL:    if (fill_done)                 state_next = REQ;
      REQ:     if (wr_ack)                    state_next = BURST;
      BURST:   if (burst_last)                state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
  end

  // FSM outputs; the buffer read address sits at word 0 until the burst
  // runs so that buffer[0] is already on wr_data when REQ begins.
  always_comb begin
    rd_fifo   = 1'b0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    busy      = (state != IDLE);
    buf_raddr = '0;
    unique case (state)
      IDLE: begin
      end
      FILL: begin
        rd_fifo = (fill_cnt < FILL_LAST);
      end
      REQ: begin
        wr_req  = 1'b1;
        wr_addr = FRAME_BASE + word_ptr;
        wr_data = buf_rdata;
      end
      BURST: begin
        wr_data   = buf_rdata;
        buf_raddr = wr_next ? idx_inc : burst_idx;
      end
      default: begin
      end
    endcase
  end

  // Fill cycle counter, restarted every time FILL is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if ((state == FILL) && !fill_done) begin
      fill_cnt <= fill_cnt + CNT_W'(1);
    end else begin
      fill_cnt <= '0;
    end
  end

  // Hold the even pixel of each pair until its odd partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_pixel <= '0;
    end else if ((state == FILL) && fill_cnt[0]) begin
      held_pixel <= pixel;
    end
  end

  // Burst word index, advanced only by wr_next while streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_idx <= '0;
    end else if (state != BURST) begin
      burst_idx <= '0;
    end else if (wr_next) begin
      burst_idx <= idx_inc;
    end
  end

  // Frame pointer and frame_start bookkeeping: a pending restart takes
  // effect only when the writer is (or is about to be) idle, so a burst in
  // flight always completes at its original address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_ptr   <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= burst_last && ptr_wrap;
      if (burst_last) begin
        pending <= 1'b0;
        if (ptr_wrap || pending || frame_start) begin
          word_ptr <= '0;
        end else begin
          word_ptr <= ptr_advanced;
        end
      end else if ((state == IDLE) && (pending || frame_start)) begin
        pending  <= 1'b0;
        word_ptr <= '0;
      end else if (frame_start) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
